// File: rtl/vm_pkg.sv
// Purpose: shared types, coin encodings and the coin-value helper for the
//          multi-item vending controller.
// Contents: state_e (FSM states), status_e (status output codes),
//           coin code localparams, coin_value() decoder.
package vm_pkg;

  localparam int unsigned VM_BAL_W = 8;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  localparam int unsigned DEF_COIN1_VAL = 5;
  localparam int unsigned DEF_COIN2_VAL = 10;
  localparam int unsigned DEF_COIN3_VAL = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_SELECTED = 3'd2,
    ST_VEND     = 3'd3,
    ST_CHANGE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK       = 2'b00,
    STAT_VENDING  = 2'b01,
    STAT_INSUFF   = 2'b10,
    STAT_SOLD_OUT = 2'b11
  } status_e;

  // Map a coin code to its credit value; code 00 is worth nothing.
  function automatic logic [VM_BAL_W-1:0] coin_value(input logic [1:0] code,
                                                     input int unsigned v1,
                                                     input int unsigned v2,
                                                     input int unsigned v3);
    logic [VM_BAL_W-1:0] val;
    case (code)
      COIN_1:  val = VM_BAL_W'(v1);
      COIN_2:  val = VM_BAL_W'(v2);
      COIN_3:  val = VM_BAL_W'(v3);
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vm_inventory.sv
// Purpose: per-item stock counter and price register file.
// Ports:
//   clk, rst            clock, async active-low reset (clears all entries)
//   valid_s/items_s     write strobe and target item (out-of-range ignored)
//   count_s/cost_s      new stock count and price
//   dec/dec_idx         decrement stock of one item by one
//   rd_idx              combinational read index
//   stock/price         read data for rd_idx (0 when out of range)
module vm_inventory
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 6,
  parameter int unsigned IDX_W     = $clog2(NUM_ITEMS),
  parameter int unsigned BAL_W     = 8,
  parameter int unsigned STOCK_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_s,
  input  logic [IDX_W-1:0]   items_s,
  input  logic [STOCK_W-1:0] count_s,
  input  logic [BAL_W-1:0]   cost_s,
  input  logic               dec,
  input  logic [IDX_W-1:0]   dec_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [STOCK_W-1:0] stock,
  output logic [BAL_W-1:0]   price
);

  logic [STOCK_W-1:0] r_stock [NUM_ITEMS];
  logic [BAL_W-1:0]   r_price [NUM_ITEMS];

  logic w_wr_ok;
  logic w_dec_ok;
  logic w_rd_ok;

  assign w_wr_ok  = valid_s && (32'(items_s) < NUM_ITEMS);
  // Never decrement an empty slot, so the counter cannot wrap.
  assign w_dec_ok = dec && (32'(dec_idx) < NUM_ITEMS) && (r_stock[dec_idx] != '0);
  assign w_rd_ok  = 32'(rd_idx) < NUM_ITEMS;

  // Storage update; decrement wins if both ever coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        r_stock[i] <= '0;
        r_price[i] <= '0;
      end
    end else if (w_dec_ok) begin
      r_stock[dec_idx] <= r_stock[dec_idx] - STOCK_W'(1);
    end else if (w_wr_ok) begin
      r_stock[items_s] <= count_s;
      r_price[items_s] <= cost_s;
    end
  end

  assign stock = w_rd_ok ? r_stock[rd_idx] : '0;
  assign price = w_rd_ok ? r_price[rd_idx] : '0;

endmodule

// File: rtl/vm_multi_ctrl.sv
// Purpose: multi-item vending controller: credit collection with saturation
//          limit, product select, purchase check, vend, change and refund.
// Ports:
//   clk, rst                        clock, async active-low reset
//   coins                           coin code this cycle (00 = none)
//   button                          one-hot product select
//   enter_key, cancel               confirm purchase / abort with refund
//   valid_s, items_s, count_s, cost_s  restock/price write (IDLE only)
//   product, vend                   vended index and one-cycle dispense pulse
//   status                          00 OK, 01 VENDING, 10 INSUFFICIENT, 11 SOLD_OUT
//   balance                         current credit
//   change, change_valid            refund amount and its one-cycle strobe
//   coin_reject                     one-cycle pulse for a coin not accepted
//   info                            price of selected item, 0 when none
module vm_multi_ctrl
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 6,
  parameter int unsigned IDX_W     = $clog2(NUM_ITEMS),
  parameter int unsigned BAL_W     = 8,
  parameter int unsigned STOCK_W   = 4,
  parameter int unsigned MAX_BAL   = 200,
  parameter int unsigned COIN1_VAL = DEF_COIN1_VAL,
  parameter int unsigned COIN2_VAL = DEF_COIN2_VAL,
  parameter int unsigned COIN3_VAL = DEF_COIN3_VAL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coins,
  input  logic [NUM_ITEMS-1:0] button,
  input  logic                 enter_key,
  input  logic                 cancel,
  input  logic                 valid_s,
  input  logic [IDX_W-1:0]     items_s,
  input  logic [STOCK_W-1:0]   count_s,
  input  logic [BAL_W-1:0]     cost_s,
  output logic [IDX_W-1:0]     product,
  output logic                 vend,
  output logic [1:0]           status,
  output logic [BAL_W-1:0]     balance,
  output logic [BAL_W-1:0]     change,
  output logic                 change_valid,
  output logic                 coin_reject,
  output logic [BAL_W-1:0]     info
);

  state_e             r_state,   w_state_nxt;
  status_e            r_status,  w_status_nxt;
  logic [BAL_W-1:0]   r_balance, w_balance_nxt;
  logic [IDX_W-1:0]   r_sel_idx, w_sel_idx_nxt;
  logic               r_sel_vld, w_sel_vld_nxt;
  logic [IDX_W-1:0]   r_product, w_product_nxt;
  logic               r_vend,    w_vend_nxt;
  logic [BAL_W-1:0]   r_change,  w_change_nxt;
  logic               r_chg_vld, w_chg_vld_nxt;
  logic               r_coin_rej, w_coin_rej_nxt;
  logic [BAL_W-1:0]   r_info,    w_info_nxt;

  logic               w_entry;
  logic               w_enter_act;
  logic               w_btn_acc;
  logic [IDX_W-1:0]   w_btn_idx;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [STOCK_W-1:0] w_stock;
  logic [BAL_W-1:0]   w_price;
  logic [BAL_W-1:0]   w_coin_val;
  logic [BAL_W:0]     w_sum;
  logic               w_coin_fits;
  logic               w_coin_acc;
  logic               w_wr_en;
  logic               w_dec;

  // Event qualification, kept outside the FSM block so the inventory read
  // index never depends on the purchase decision that uses its result.
  assign w_entry     = (r_state == ST_IDLE) || (r_state == ST_COLLECT) ||
                       (r_state == ST_SELECTED);
  assign w_enter_act = enter_key && (r_state == ST_SELECTED);
  assign w_btn_acc   = w_entry && !cancel && !w_enter_act && $onehot(button);
  // Read the newly pressed item so info shows its price the next cycle.
  assign w_rd_idx    = w_btn_acc ? w_btn_idx : r_sel_idx;

  // One-hot button to index.
  always_comb begin
    w_btn_idx = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (button[i]) w_btn_idx = IDX_W'(i);
    end
  end

  assign w_coin_val  = BAL_W'(coin_value(coins, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign w_sum       = {1'b0, r_balance} + {1'b0, w_coin_val};
  assign w_coin_fits = w_sum <= (BAL_W+1)'(MAX_BAL);

  vm_inventory #(
    .NUM_ITEMS (NUM_ITEMS),
    .IDX_W     (IDX_W),
    .BAL_W     (BAL_W),
    .STOCK_W   (STOCK_W)
  ) u_inv (
    .clk     (clk),
    .rst     (rst),
    .valid_s (w_wr_en),
    .items_s (items_s),
    .count_s (count_s),
    .cost_s  (cost_s),
    .dec     (w_dec),
    .dec_idx (r_sel_idx),
    .rd_idx  (w_rd_idx),
    .stock   (w_stock),
    .price   (w_price)
  );

  // Next-state and registered-output logic; priority cancel > enter > button
  // > coins > restock, and only the winning event takes effect.
  always_comb begin
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_balance_nxt = r_balance;
    w_sel_idx_nxt = r_sel_idx;
    w_sel_vld_nxt = r_sel_vld;
    w_product_nxt = r_product;
    w_vend_nxt    = 1'b0;
    w_change_nxt  = '0;
    w_chg_vld_nxt = 1'b0;
    w_coin_acc    = 1'b0;
    w_wr_en       = 1'b0;
    w_dec         = 1'b0;

    case (r_state)
      ST_IDLE, ST_COLLECT, ST_SELECTED: begin
        if (cancel) begin
          w_change_nxt  = r_balance;
          w_chg_vld_nxt = 1'b1;
          w_balance_nxt = '0;
          w_sel_vld_nxt = 1'b0;
          w_status_nxt  = STAT_OK;
          w_state_nxt   = ST_IDLE;
        end else if (w_enter_act) begin
          if (w_stock == '0) begin
            w_status_nxt = STAT_SOLD_OUT;
          end else if (r_balance < w_price) begin
            w_status_nxt = STAT_INSUFF;
          end else begin
            w_state_nxt   = ST_VEND;
            w_vend_nxt    = 1'b1;
            w_product_nxt = r_sel_idx;
            w_status_nxt  = STAT_VENDING;
          end
        end else if (w_btn_acc) begin
          w_sel_vld_nxt = 1'b1;
          w_sel_idx_nxt = w_btn_idx;
          w_status_nxt  = STAT_OK;
          w_state_nxt   = ST_SELECTED;
        end else if (coins != COIN_NONE) begin
          if (w_coin_fits) begin
            w_coin_acc    = 1'b1;
            w_balance_nxt = w_sum[BAL_W-1:0];
            if (r_state == ST_IDLE) w_state_nxt = ST_COLLECT;
          end
        end else if (valid_s && (r_state == ST_IDLE)) begin
          w_wr_en = 1'b1;
        end
      end
      // Dispense cycle: consume stock and prepare the change pulse.
      ST_VEND: begin
        w_dec         = 1'b1;
        w_change_nxt  = r_balance - w_price;
        w_chg_vld_nxt = 1'b1;
        w_balance_nxt = '0;
        w_sel_vld_nxt = 1'b0;
        w_status_nxt  = STAT_OK;
        w_state_nxt   = ST_CHANGE;
      end
      ST_CHANGE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_coin_rej_nxt = (coins != COIN_NONE) && !w_coin_acc;
    w_info_nxt     = w_sel_vld_nxt ? w_price : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_status   <= STAT_OK;
      r_balance  <= '0;
      r_sel_idx  <= '0;
      r_sel_vld  <= 1'b0;
      r_product  <= '0;
      r_vend     <= 1'b0;
      r_change   <= '0;
      r_chg_vld  <= 1'b0;
      r_coin_rej <= 1'b0;
      r_info     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_status   <= w_status_nxt;
      r_balance  <= w_balance_nxt;
      r_sel_idx  <= w_sel_idx_nxt;
      r_sel_vld  <= w_sel_vld_nxt;
      r_product  <= w_product_nxt;
      r_vend     <= w_vend_nxt;
      r_change   <= w_change_nxt;
      r_chg_vld  <= w_chg_vld_nxt;
      r_coin_rej <= w_coin_rej_nxt;
      r_info     <= w_info_nxt;
    end
  end

  assign product      = r_product;
  assign vend         = r_vend;
  assign status       = r_status;
  assign balance      = r_balance;
  assign change       = r_change;
  assign change_valid = r_chg_vld;
  assign coin_reject  = r_coin_rej;
  assign info         = r_info;

endmodule

// File: tb/tb_vm_multi_ctrl.sv
// Purpose: self-checking bench for vm_multi_ctrl (default parameters).
module tb_vm_multi_ctrl;

  typedef struct {
    logic [1:0] coins;
    logic [5:0] btn;
    logic       ent;
    logic       can;
    logic       vs;
    logic [2:0] it;
    logic [3:0] cnt;
    logic [7:0] cost;
    logic       e_vend;
    logic [2:0] e_prod;
    logic [1:0] e_st;
    logic [7:0] e_bal;
    logic       e_cv;
    logic [7:0] e_chg;
    logic       e_rej;
    logic [7:0] e_info;
  } vec_t;

  localparam logic [1:0] C5 = 2'b01, C10 = 2'b10, C25 = 2'b11;
  localparam logic [5:0] B1 = 6'b000010, B2 = 6'b000100, B4 = 6'b010000,
                         B5 = 6'b100000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coins;
  logic [5:0] button;
  logic       enter_key, cancel, valid_s;
  logic [2:0] items_s;
  logic [3:0] count_s;
  logic [7:0] cost_s;
  logic [2:0] product;
  logic       vend;
  logic [1:0] status;
  logic [7:0] balance, change;
  logic       change_valid, coin_reject;
  logic [7:0] info;

  int total = 0;
  int bad   = 0;
  vec_t sb[$];
  vec_t tbl[27];

  vm_multi_ctrl dut (
    .clk(clk), .rst(rst), .coins(coins), .button(button),
    .enter_key(enter_key), .cancel(cancel), .valid_s(valid_s),
    .items_s(items_s), .count_s(count_s), .cost_s(cost_s),
    .product(product), .vend(vend), .status(status), .balance(balance),
    .change(change), .change_valid(change_valid), .coin_reject(coin_reject),
    .info(info)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] c, logic [5:0] b, logic e, logic x,
                              logic vs, logic [2:0] it, logic [3:0] cnt,
                              logic [7:0] cost, logic ev, logic [2:0] ep,
                              logic [1:0] es, logic [7:0] eb, logic ecv,
                              logic [7:0] ech, logic erj, logic [7:0] ei);
    vec_t v;
    v.coins = c; v.btn = b; v.ent = e; v.can = x; v.vs = vs; v.it = it;
    v.cnt = cnt; v.cost = cost; v.e_vend = ev; v.e_prod = ep; v.e_st = es;
    v.e_bal = eb; v.e_cv = ecv; v.e_chg = ech; v.e_rej = erj; v.e_info = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".vend"},        int'(vend),         int'(v.e_vend));
    chk({tag, ".product"},     int'(product),      int'(v.e_prod));
    chk({tag, ".status"},      int'(status),       int'(v.e_st));
    chk({tag, ".balance"},     int'(balance),      int'(v.e_bal));
    chk({tag, ".change_valid"}, int'(change_valid), int'(v.e_cv));
    chk({tag, ".change"},      int'(change),       int'(v.e_chg));
    chk({tag, ".coin_reject"}, int'(coin_reject),  int'(v.e_rej));
    chk({tag, ".info"},        int'(info),         int'(v.e_info));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    coins = v.coins; button = v.btn; enter_key = v.ent; cancel = v.can;
    valid_s = v.vs; items_s = v.it; count_s = v.cnt; cost_s = v.cost;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outs(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t z;
    rst = 1'b0;
    coins = '0; button = '0; enter_key = 1'b0; cancel = 1'b0; valid_s = 1'b0;
    items_s = '0; count_s = '0; cost_s = '0;

    // Purchase, sold-out, insufficient, invalid button and blocked restock.
    tbl[0]  = mk(2'b0, 6'b0, 0, 0, 1, 3'd2, 4'd3, 8'd30, 0, 3'd0, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);
    tbl[1]  = mk(2'b0, 6'b0, 0, 0, 1, 3'd4, 4'd0, 8'd10, 0, 3'd0, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);
    tbl[2]  = mk(2'b0, 6'b0, 0, 0, 1, 3'd5, 4'd2, 8'd50, 0, 3'd0, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);
    tbl[3]  = mk(C25,  6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd0, 2'd0, 8'd25, 0, 8'd0,  0, 8'd0);
    tbl[4]  = mk(C10,  6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd0, 2'd0, 8'd35, 0, 8'd0,  0, 8'd0);
    tbl[5]  = mk(2'b0, B2,   0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd0, 2'd0, 8'd35, 0, 8'd0,  0, 8'd30);
    tbl[6]  = mk(2'b0, 6'b0, 1, 0, 0, 3'd0, 4'd0, 8'd0,  1, 3'd2, 2'd1, 8'd35, 0, 8'd0,  0, 8'd30);
    tbl[7]  = mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd0,  1, 8'd5,  0, 8'd0);
    tbl[8]  = mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);
    tbl[9]  = mk(C25,  6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd25, 0, 8'd0,  0, 8'd0);
    tbl[10] = mk(2'b0, B4,   0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd25, 0, 8'd0,  0, 8'd10);
    tbl[11] = mk(2'b0, 6'b0, 1, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd3, 8'd25, 0, 8'd0,  0, 8'd10);
    tbl[12] = mk(2'b0, 6'b0, 0, 1, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd0,  1, 8'd25, 0, 8'd0);
    tbl[13] = mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);
    tbl[14] = mk(C25,  6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd25, 0, 8'd0,  0, 8'd0);
    tbl[15] = mk(2'b0, B5,   0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd0, 8'd25, 0, 8'd0,  0, 8'd50);
    tbl[16] = mk(C25,  6'b0, 1, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd2, 8'd25, 0, 8'd0,  1, 8'd50);
    tbl[17] = mk(C25,  6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd2, 2'd2, 8'd50, 0, 8'd0,  0, 8'd50);
    tbl[18] = mk(2'b0, 6'b0, 1, 0, 0, 3'd0, 4'd0, 8'd0,  1, 3'd5, 2'd1, 8'd50, 0, 8'd0,  0, 8'd50);
    tbl[19] = mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd5, 2'd0, 8'd0,  1, 8'd0,  0, 8'd0);
    tbl[20] = mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd5, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);
    tbl[21] = mk(2'b0, 6'b000110, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd0, 0, 8'd0, 0, 8'd0);
    tbl[22] = mk(C5,   6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd5, 2'd0, 8'd5,  0, 8'd0,  0, 8'd0);
    tbl[23] = mk(2'b0, 6'b0, 0, 0, 1, 3'd2, 4'd9, 8'd99, 0, 3'd5, 2'd0, 8'd5,  0, 8'd0,  0, 8'd0);
    tbl[24] = mk(2'b0, B2,   0, 0, 0, 3'd0, 4'd0, 8'd0,  0, 3'd5, 2'd0, 8'd5,  0, 8'd0,  0, 8'd30);
    tbl[25] = mk(2'b0, 6'b0, 0, 1, 0, 3'd0, 4'd0, 8'd0,  0, 3'd5, 2'd0, 8'd0,  1, 8'd5,  0, 8'd0);
    tbl[26] = mk(2'b0, 6'b0, 0, 0, 1, 3'd6, 4'd5, 8'd7,  0, 3'd5, 2'd0, 8'd0,  0, 8'd0,  0, 8'd0);

    // Reset state while held in reset.
    z = mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd0, 2'd0, 8'd0, 0, 8'd0, 0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", z);
    rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end
    chk("stock2", int'(dut.u_inv.r_stock[2]), 2);
    chk("stock5", int'(dut.u_inv.r_stock[5]), 1);
    chk("stock4", int'(dut.u_inv.r_stock[4]), 0);

    // Balance ceiling: 8 x 25 reaches 200, a further 5 is rejected.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sat%0d", i),
           mk(C25, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'(25 * (i + 1)), 0, 8'd0, 0, 8'd0));
    end
    step("sat_rej",  mk(C5,   6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd200, 0, 8'd0,   1, 8'd0));
    step("sat_hold", mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd200, 0, 8'd0,   0, 8'd0));
    step("sat_can",  mk(2'b0, 6'b0, 0, 1, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd0,   1, 8'd200, 0, 8'd0));
    step("sat_idle", mk(2'b0, 6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd0,   0, 8'd0,   0, 8'd0));

    // Reset asserted while the dispense pulse is high.
    step("rv_stock", mk(2'b0, 6'b0, 0, 0, 1, 3'd1, 4'd1, 8'd5, 0, 3'd5, 2'd0, 8'd0, 0, 8'd0, 0, 8'd0));
    step("rv_coin",  mk(C5,   6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd5, 0, 8'd0, 0, 8'd0));
    step("rv_sel",   mk(2'b0, B1,   0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd5, 2'd0, 8'd5, 0, 8'd0, 0, 8'd5));
    step("rv_ent",   mk(2'b0, 6'b0, 1, 0, 0, 3'd0, 4'd0, 8'd0, 1, 3'd1, 2'd1, 8'd5, 0, 8'd0, 0, 8'd5));
    rst = 1'b0;
    coins = '0; button = '0; enter_key = 1'b0; cancel = 1'b0; valid_s = 1'b0;
    #1;
    check_outs("rv_async", z);
    chk("rv_stock1", int'(dut.u_inv.r_stock[1]), 0);
    chk("rv_stock2", int'(dut.u_inv.r_stock[2]), 0);
    @(negedge clk);
    rst = 1'b1;
    step("rv_idle",  z);
    step("rv_c25",   mk(C25,  6'b0, 0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd0, 2'd0, 8'd25, 0, 8'd0,  0, 8'd0));
    step("rv_sel2",  mk(2'b0, B1,   0, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd0, 2'd0, 8'd25, 0, 8'd0,  0, 8'd0));
    step("rv_sold",  mk(2'b0, 6'b0, 1, 0, 0, 3'd0, 4'd0, 8'd0, 0, 3'd0, 2'd3, 8'd25, 0, 8'd0,  0, 8'd0));
    step("rv_can",   mk(2'b0, 6'b0, 0, 1, 0, 3'd0, 4'd0, 8'd0, 0, 3'd0, 2'd0, 8'd0,  1, 8'd25, 0, 8'd0));
    step("rv_end",   z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vm_multi_ctrl.md
Name: vm_multi_ctrl

Overview:
- Parametrised next-generation vending-machine controller: N products, each with a programmable price and stock count.
- Adds saturating balance, cancel/refund, change output, sold-out detection and coin rejection.
- Sits beside the testbench in the vending top, driven by coin, button, enter-key and restock stimulus.

Parameters:
- NUM_ITEMS, 6, number of products; also the width of the button bus.
- IDX_W, $clog2(NUM_ITEMS), product index width.
- BAL_W, 8, width of balance, price and change.
- STOCK_W, 4, width of the per-item stock counter.
- MAX_BAL, 200, balance ceiling; must be < 2**BAL_W.
- COIN1_VAL / COIN2_VAL / COIN3_VAL, 5 / 10 / 25, values of coin codes 01 / 10 / 11.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coins  in  2  coin inserted this cycle; 00 = none.
- button  in  NUM_ITEMS  product select; only one-hot values are valid.
- enter_key  in  1  confirm purchase.
- cancel  in  1  abort transaction and refund.
- valid_s  in  1  restock/price write strobe.
- items_s  in  IDX_W  restock target item.
- count_s  in  STOCK_W  new stock count.
- cost_s  in  BAL_W  new price.
- product  out  IDX_W  index of the vended item.
- vend  out  1  one-cycle dispense pulse.
- status  out  2  00 OK, 01 VENDING, 10 INSUFFICIENT, 11 SOLD_OUT.
- balance  out  BAL_W  current credit.
- change  out  BAL_W  refund amount, valid with change_valid.
- change_valid  out  1  one-cycle pulse.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- info  out  BAL_W  price of the currently selected item; 0 when none is selected.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Selection cleared. All stock=0, all prices=0.
- States: IDLE, COLLECT, SELECTED, VEND, CHANGE.
- Priority within a cycle: cancel > enter_key > button > coins > valid_s.
- Coins, accepted in IDLE / COLLECT / SELECTED:
  - If balance+value <= MAX_BAL: registered next cycle; IDLE->COLLECT.
  - Otherwise: coin_reject pulses and balance is unchanged.
  - Coins in VEND / CHANGE are always rejected.
- Button, accepted in IDLE / COLLECT / SELECTED:
  - Valid one-hot: latches the index; state goes to SELECTED; info = price[idx] next cycle; status = OK.
  - Zero or multi-hot: ignored.
- enter_key in SELECTED (checks use the registered balance; a same-cycle coin is rejected):
  - stock[idx]==0: status=SOLD_OUT, stay in SELECTED.
  - balance<price[idx]: status=INSUFFICIENT, stay in SELECTED.
  - Otherwise: go to VEND.
  - enter_key in any other state: ignored.
- VEND (1 cycle): vend=1, product=idx, status=VENDING, stock[idx] decrements. Next state CHANGE.
- CHANGE (1 cycle):
  - change=balance-price, change_valid=1 (a pulse even when change is 0).
  - balance->0, selection cleared, status=OK. Next state IDLE.
- cancel in IDLE / COLLECT / SELECTED:
  - change=balance, change_valid=1 next cycle; balance->0; selection cleared; state IDLE.
  - cancel is ignored in VEND / CHANGE, so an in-flight vend always completes.
- Restock:
  - valid_s is honoured only in IDLE: writes stock and price of items_s next cycle.
  - Ignored in any other state, or when items_s>=NUM_ITEMS.
- Stock never wraps; a decrement at 0 is unreachable because of the SOLD_OUT check.
- status is sticky until the next accepted button, enter_key, cancel or vend.
- Reset mid-VEND: the vend is lost. Stock and balance return to their reset values.

Decomposition:
- Package vm_pkg:
  - state_e enum.
  - status_e enum (OK, VENDING, INSUFFICIENT, SOLD_OUT).
  - Coin code localparams.
  - Function coin_value(code) returning BAL_W bits.
- Sub-module vm_inventory: per-item stock/price register file.
  - Write port: valid_s / items_s / count_s / cost_s.
  - Decrement port: dec, dec_idx.
  - Read port: rd_idx -> stock, price.
- The top-level FSM, balance and change logic live in vm_multi_ctrl.

Test Plan:
- Restock item 2 with count 3, price 30. Coins 25+10. Press button[2], then enter -> vend=1, product=2, change_valid with change=5, balance=0, stock[2]=2.
- Item 4 with stock 0, price 10. Insert 25, press button[4], enter -> status=SOLD_OUT, no vend. Then cancel -> change=25, state IDLE.
- Price 50. Insert 25, select, enter -> status=INSUFFICIENT. Insert 25, enter -> vend, change=0 with change_valid=1.
- Insert 8 × 25 (balance 200), then one more 5 -> coin_reject=1, balance stays 200.
- button=6'b000110 -> ignored, info=0. Restock pulse while in COLLECT -> inventory unchanged.
- Assert rst low during VEND -> all outputs 0 immediately (async), stock cleared, no change_valid.
